brownout_ctrl: RTL and testbench



---
 rtl/brownout_pkg.sv | 26 ++
 rtl/brownout_ctrl_if.sv | 26 ++
 rtl/brownout_filt.sv | 44 ++++
 rtl/brownout_ctrl.sv | 159 +++++++++++++++
 tb/tb_brownout_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/brownout_pkg.sv
// Shared types and helpers for the brownout digital sequencer.
package brownout_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned DEC_W  = 8;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DEC_W-1:0]  dec_t;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ARMED   = 3'd2,
    ST_TRIPPED = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  // 3-to-8 one-hot select for the resistor-string mux
  function automatic dec_t decode_code(input code_t i_code);
    dec_t v_dec;
    v_dec         = '0;
    v_dec[i_code] = 1'b1;
    return v_dec;
  endfunction

endpackage

// File: rtl/brownout_ctrl_if.sv
// Register-bank / analog-macro side signals of the brownout sequencer.
interface brownout_ctrl_if;
  import brownout_pkg::*;

  logic  ena;
  code_t otrip;
  code_t vtrip;
  logic  dcomp;
  logic  vunder_raw;
  logic  ana_ena;
  dec_t  otrip_decoded;
  dec_t  vtrip_decoded;
  logic  brout_filt;
  logic  vunder;
  logic  ready;

  modport master (
    output ena, otrip, vtrip, dcomp, vunder_raw,
    input  ana_ena, otrip_decoded, vtrip_decoded, brout_filt, vunder, ready
  );

  modport slave (
    input  ena, otrip, vtrip, dcomp, vunder_raw,
    output ana_ena, otrip_decoded, vtrip_decoded, brout_filt, vunder, ready
  );
endinterface

// File: rtl/brownout_filt.sv
// Two-flop synchronizer plus saturating counter of consecutive samples at a target level.
module brownout_filt #(
  parameter int unsigned FILT_CYCLES = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  input  logic i_target,
  input  logic i_clr,
  output logic o_sync,
  output logic o_done_c
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(FILT_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             w_match;

  assign w_match = (r_s2 == i_target);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (i_clr || !w_match) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Done on the sample that would complete FILT_CYCLES in a row
  assign o_done_c = !i_clr && w_match && (r_cnt >= LP_LAST);
  assign o_sync   = r_s2;

endmodule

// File: rtl/brownout_ctrl.sv
// Brownout sequencer: analog enable/settle, trip-code decode, comparator filtering and hold.
module brownout_ctrl
  import brownout_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned FILT_CYCLES   = 8,
  parameter int unsigned HOLD_CYCLES   = 32,
  parameter int unsigned CNT_W         = 8
) (
  input  logic           osc_ck,
  input  logic           rstn,
  brownout_ctrl_if.slave io_bus
);

  localparam logic [CNT_W-1:0] LP_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  code_t            r_otrip;
  code_t            r_vtrip;
  dec_t             r_otrip_dec;
  dec_t             r_vtrip_dec;
  logic             r_ana_ena;
  logic             r_brout;
  logic             r_vunder;
  logic             r_ready;

  logic w_filt_clr;
  logic w_d_target;
  logic w_d_sync;
  logic w_d_done;
  logic w_v_sync;
  logic w_v_done;
  logic w_code_chg;
  logic w_active;

  assign w_filt_clr = (r_state == ST_OFF) || (r_state == ST_SETTLE);
  assign w_active   = !w_filt_clr;
  // Once tripped, the brownout filter looks for the comparator releasing
  assign w_d_target = !((r_state == ST_TRIPPED) || (r_state == ST_HOLD));
  assign w_code_chg = (io_bus.otrip != r_otrip) || (io_bus.vtrip != r_vtrip);

  brownout_filt #(
    .FILT_CYCLES(FILT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_dcomp_filt (
    .i_clk   (osc_ck),
    .i_rst_n (rstn),
    .i_raw   (io_bus.dcomp),
    .i_target(w_d_target),
    .i_clr   (w_filt_clr),
    .o_sync  (w_d_sync),
    .o_done_c(w_d_done)
  );

  brownout_filt #(
    .FILT_CYCLES(FILT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_vunder_filt (
    .i_clk   (osc_ck),
    .i_rst_n (rstn),
    .i_raw   (io_bus.vunder_raw),
    .i_target(!r_vunder),
    .i_clr   (w_filt_clr),
    .o_sync  (w_v_sync),
    .o_done_c(w_v_done)
  );

  always_ff @(posedge osc_ck or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_OFF;
      r_cnt       <= '0;
      r_otrip     <= '0;
      r_vtrip     <= '0;
      r_otrip_dec <= decode_code(CODE_W'(0));
      r_vtrip_dec <= decode_code(CODE_W'(0));
      r_ana_ena   <= 1'b0;
      r_brout     <= 1'b0;
      r_vunder    <= 1'b0;
      r_ready     <= 1'b0;
    end else if (!io_bus.ena) begin
      // Selects keep the last code so the resistor string stays defined
      r_state   <= ST_OFF;
      r_cnt     <= '0;
      r_ana_ena <= 1'b0;
      r_brout   <= 1'b0;
      r_vunder  <= 1'b0;
      r_ready   <= 1'b0;
    end else if ((r_state == ST_OFF) || w_code_chg) begin
      // Power-up or new code: recapture and re-settle; a held brownout flag survives
      r_state     <= ST_SETTLE;
      r_cnt       <= '0;
      r_otrip     <= io_bus.otrip;
      r_vtrip     <= io_bus.vtrip;
      r_otrip_dec <= decode_code(io_bus.otrip);
      r_vtrip_dec <= decode_code(io_bus.vtrip);
      r_ana_ena   <= 1'b1;
      r_brout     <= (r_state == ST_OFF) ? 1'b0 : r_brout;
      r_vunder    <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cnt == LP_SETTLE_LAST) begin
            r_state <= ST_ARMED;
            r_cnt   <= '0;
            r_brout <= 1'b0;
            r_ready <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ARMED: begin
          if (w_d_done) begin
            r_state <= ST_TRIPPED;
            r_brout <= 1'b1;
          end
        end
        ST_TRIPPED: begin
          if (w_d_done) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (w_d_sync) begin
            r_state <= ST_TRIPPED;
            r_cnt   <= '0;
          end else if (r_cnt == LP_HOLD_LAST) begin
            r_state <= ST_ARMED;
            r_cnt   <= '0;
            r_brout <= 1'b0;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= ST_OFF;
          r_cnt     <= '0;
          r_ana_ena <= 1'b0;
          r_brout   <= 1'b0;
          r_ready   <= 1'b0;
        end
      endcase
      if (w_active && w_v_done) begin
        r_vunder <= w_v_sync;
      end
    end
  end

  assign io_bus.ana_ena       = r_ana_ena;
  assign io_bus.otrip_decoded = r_otrip_dec;
  assign io_bus.vtrip_decoded = r_vtrip_dec;
  assign io_bus.brout_filt    = r_brout;
  assign io_bus.vunder        = r_vunder;
  assign io_bus.ready         = r_ready;

endmodule

// File: tb/tb_brownout_ctrl.sv
// Directed bench for brownout_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_brownout_ctrl;

  logic osc_ck;
  logic rstn;
  int   total;
  int   bad;

  brownout_ctrl_if bus_if ();

  brownout_ctrl dut (
    .osc_ck(osc_ck),
    .rstn  (rstn),
    .io_bus(bus_if)
  );

  initial osc_ck = 1'b0;
  always #5 osc_ck = ~osc_ck;

  typedef struct {
    string       name;
    logic        ena;
    logic [2:0]  ot;
    logic [2:0]  vt;
    logic        dc;
    logic        vr;
    int unsigned n;
    logic        e_ana;
    logic        e_brout;
    logic        e_vun;
    logic        e_rdy;
    logic [7:0]  e_od;
    logic [7:0]  e_vd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(string nm, logic en, logic [2:0] ot, logic [2:0] vt,
                                  logic dc, logic vr, int unsigned n, logic ea, logic eb,
                                  logic ev, logic er, logic [7:0] eod, logic [7:0] evd);
    vec_t v;
    v.name = nm; v.ena = en; v.ot = ot; v.vt = vt; v.dc = dc; v.vr = vr; v.n = n;
    v.e_ana = ea; v.e_brout = eb; v.e_vun = ev; v.e_rdy = er; v.e_od = eod; v.e_vd = evd;
    vecs.push_back(v);
  endfunction

  task automatic step(input int unsigned n);
    repeat (n) @(negedge osc_ck);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic ea, input logic eb, input logic ev,
                         input logic er, input logic [7:0] eod, input logic [7:0] evd);
    chk1({nm, ".ana_ena"}, bus_if.ana_ena, ea);
    chk1({nm, ".brout_filt"}, bus_if.brout_filt, eb);
    chk1({nm, ".vunder"}, bus_if.vunder, ev);
    chk1({nm, ".ready"}, bus_if.ready, er);
    chk8({nm, ".otrip_dec"}, bus_if.otrip_decoded, eod);
    chk8({nm, ".vtrip_dec"}, bus_if.vtrip_decoded, evd);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    bus_if.ena        = 1'b0;
    bus_if.otrip      = 3'd0;
    bus_if.vtrip      = 3'd0;
    bus_if.dcomp      = 1'b0;
    bus_if.vunder_raw = 1'b0;

    //       name           en ot vt dc vr   n  ana br vun rdy  od     vd
    add_vec("en_on",        1, 3, 5, 0, 0,   1, 1, 0, 0, 0, 8'h08, 8'h20);
    add_vec("settle",       1, 3, 5, 0, 0,  63, 1, 0, 0, 0, 8'h08, 8'h20);
    add_vec("ready",        1, 3, 5, 0, 0,   1, 1, 0, 0, 1, 8'h08, 8'h20);
    add_vec("glitch7",      1, 3, 5, 1, 0,   7, 1, 0, 0, 1, 8'h08, 8'h20);
    add_vec("glitch_end",   1, 3, 5, 0, 0,  12, 1, 0, 0, 1, 8'h08, 8'h20);
    add_vec("trip_pre",     1, 3, 5, 1, 0,   9, 1, 0, 0, 1, 8'h08, 8'h20);
    add_vec("trip",         1, 3, 5, 1, 0,   1, 1, 1, 0, 1, 8'h08, 8'h20);
    add_vec("rel_pre",      1, 3, 5, 0, 0,  41, 1, 1, 0, 1, 8'h08, 8'h20);
    add_vec("rel",          1, 3, 5, 0, 0,   1, 1, 0, 0, 1, 8'h08, 8'h20);
    add_vec("vun_pre",      1, 3, 5, 0, 1,   9, 1, 0, 0, 1, 8'h08, 8'h20);
    add_vec("vun_set",      1, 3, 5, 0, 1,   1, 1, 0, 1, 1, 8'h08, 8'h20);
    add_vec("code_chg",     1, 6, 5, 0, 1,   1, 1, 0, 0, 0, 8'h40, 8'h20);
    add_vec("settle2",      1, 6, 5, 0, 1,  63, 1, 0, 0, 0, 8'h40, 8'h20);
    add_vec("rearm",        1, 6, 5, 0, 1,   1, 1, 0, 0, 1, 8'h40, 8'h20);
    add_vec("vun_pre2",     1, 6, 5, 0, 1,   7, 1, 0, 0, 1, 8'h40, 8'h20);
    add_vec("vun_set2",     1, 6, 5, 0, 1,   1, 1, 0, 1, 1, 8'h40, 8'h20);
    add_vec("vun_fall_pre", 1, 6, 5, 0, 0,   9, 1, 0, 1, 1, 8'h40, 8'h20);
    add_vec("vun_fall",     1, 6, 5, 0, 0,   1, 1, 0, 0, 1, 8'h40, 8'h20);
    add_vec("trip2",        1, 6, 5, 1, 0,  10, 1, 1, 0, 1, 8'h40, 8'h20);
    add_vec("code_trip",    1, 6, 2, 1, 0,   1, 1, 1, 0, 0, 8'h40, 8'h04);
    add_vec("settle3",      1, 6, 2, 1, 0,  63, 1, 1, 0, 0, 8'h40, 8'h04);
    add_vec("reeval",       1, 6, 2, 1, 0,   1, 1, 0, 0, 1, 8'h40, 8'h04);
    add_vec("retrip",       1, 6, 2, 1, 0,   8, 1, 1, 0, 1, 8'h40, 8'h04);
    add_vec("ena_off",      0, 6, 2, 1, 0,   1, 0, 0, 0, 0, 8'h40, 8'h04);

    step(2);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus_if.ena        = vecs[i].ena;
      bus_if.otrip      = vecs[i].ot;
      bus_if.vtrip      = vecs[i].vt;
      bus_if.dcomp      = vecs[i].dc;
      bus_if.vunder_raw = vecs[i].vr;
      step(vecs[i].n);
      chk_all(vecs[i].name, vecs[i].e_ana, vecs[i].e_brout, vecs[i].e_vun,
              vecs[i].e_rdy, vecs[i].e_od, vecs[i].e_vd);
    end

    // Re-enable, trip, then a 10-cycle re-trip pulse in HOLD restarts the release timer
    bus_if.ena   = 1'b1;
    bus_if.dcomp = 1'b0;
    step(64);
    chk1("reen_settle.ready", bus_if.ready, 1'b0);
    step(1);
    chk1("reen_armed.ready", bus_if.ready, 1'b1);
    bus_if.dcomp = 1'b1;
    step(10);
    chk1("h_trip.brout", bus_if.brout_filt, 1'b1);
    bus_if.dcomp = 1'b0;
    step(20);
    bus_if.dcomp = 1'b1;
    step(10);
    bus_if.dcomp = 1'b0;
    step(12);
    chk1("h_retrip_held.brout", bus_if.brout_filt, 1'b1);
    step(29);
    chk1("h_rel_pre.brout", bus_if.brout_filt, 1'b1);
    step(1);
    chk1("h_rel.brout", bus_if.brout_filt, 1'b0);
    chk1("h_rel.ready", bus_if.ready, 1'b1);

    // Asynchronous reset in the middle of HOLD
    bus_if.dcomp = 1'b1;
    step(10);
    chk1("r_trip.brout", bus_if.brout_filt, 1'b1);
    bus_if.dcomp = 1'b0;
    step(15);
    chk1("r_hold.brout", bus_if.brout_filt, 1'b1);
    rstn = 1'b0;
    #1;
    chk_all("r_async", 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01);
    rstn = 1'b1;
    step(1);
    chk1("r_restart.ana", bus_if.ana_ena, 1'b1);
    chk8("r_restart.od", bus_if.otrip_decoded, 8'h40);
    step(63);
    chk1("r_settle.ready", bus_if.ready, 1'b0);
    step(1);
    chk1("r_armed.ready", bus_if.ready, 1'b1);

    // vunder_raw toggling every 4 cycles never qualifies
    for (int k = 0; k < 8; k++) begin
      bus_if.vunder_raw = ~bus_if.vunder_raw;
      step(4);
      chk1("vtoggle.vunder", bus_if.vunder, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
